// File: rtl/cnn_pkg.sv
// Shared fixed-point types, saturation helper and FSM encoding for the CNN
// training datapath blocks.
package cnn_pkg;

    typedef logic signed [15:0] q88_t;
    typedef logic signed [31:0] q1616_t;

    localparam int   FRAC_BITS = 8;
    localparam q88_t Q_MAX     = 16'sh7FFF;
    localparam q88_t Q_MIN     = 16'sh8000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MASK,
        S_ACCUM,
        S_WRITE
    } kupd_state_e;

    // Callers sign-extend their wide intermediate into 48 bits before clamping.
    function automatic q88_t sat16(input logic signed [47:0] v);
        if (v > 48'sd32767)
            return Q_MAX;
        else if (v < -48'sd32768)
            return Q_MIN;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/conv_kernel_update_if.sv
// Request/response bundle between a conv filter's backprop controller and
// its kernel-update unit.
interface conv_kernel_update_if
    import cnn_pkg::*;
#(
    parameter int IN_SIZE     = 4,
    parameter int KERNEL_SIZE = 3
);
    localparam int OUT_SIZE = IN_SIZE - KERNEL_SIZE + 1;

    logic start;
    q88_t input_feature [IN_SIZE][IN_SIZE];
    q88_t conv_out      [OUT_SIZE][OUT_SIZE];
    q88_t dL_dact       [OUT_SIZE][OUT_SIZE];
    q88_t learning_rate;
    q88_t kernel_in     [KERNEL_SIZE][KERNEL_SIZE];
    q88_t kernel_out    [KERNEL_SIZE][KERNEL_SIZE];
    logic busy;
    logic done;

    modport master (
        output start, input_feature, conv_out, dL_dact, learning_rate, kernel_in,
        input  kernel_out, busy, done
    );

    modport slave (
        input  start, input_feature, conv_out, dL_dact, learning_rate, kernel_in,
        output kernel_out, busy, done
    );

endinterface

// File: rtl/conv_kernel_update_seq_mac.sv
// Sequential signed 16x16 multiply-accumulate with synchronous clear and enable.
module seq_mac
    import cnn_pkg::*;
#(
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  q88_t                    i_a,
    input  q88_t                    i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    q1616_t                  w_prod;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod = i_a * i_b;
    assign o_acc  = r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

endmodule

// File: rtl/conv_kernel_update.sv
// Backward pass for one conv filter: ReLU-masked gradient correlated with the
// input image, followed by an SGD step on each of the K*K kernel weights.
module conv_kernel_update
    import cnn_pkg::*;
#(
    parameter int IN_SIZE     = 4,
    parameter int KERNEL_SIZE = 3
) (
    input logic                 clk,
    input logic                 rst,
    conv_kernel_update_if.slave bus
);

    localparam int OUT_SIZE = IN_SIZE - KERNEL_SIZE + 1;
    localparam int NPIX     = OUT_SIZE * OUT_SIZE;
    localparam int ACC_W    = 32 + $clog2(NPIX);
    localparam int KW       = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int IW       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

    kupd_state_e r_state, w_next;

    q88_t r_in    [IN_SIZE][IN_SIZE];
    q88_t r_cout  [OUT_SIZE][OUT_SIZE];
    q88_t r_dl    [OUT_SIZE][OUT_SIZE];
    q88_t r_delta [OUT_SIZE][OUT_SIZE];
    q88_t r_kin   [KERNEL_SIZE][KERNEL_SIZE];
    q88_t r_stage [KERNEL_SIZE][KERNEL_SIZE];
    q88_t r_kout  [KERNEL_SIZE][KERNEL_SIZE];
    q88_t r_lr;

    logic [KW-1:0] r_m, r_n;
    logic [OW-1:0] r_pi, r_pj;
    logic          r_done;

    logic w_latch, w_mask, w_mac_en, w_write, w_busy;
    logic w_pix_last, w_k_last;

    q88_t                    w_a, w_b;
    logic signed [ACC_W-1:0] w_acc;
    q88_t                    w_grad;
    q1616_t                  w_upd;
    logic signed [47:0]      w_diff;
    q88_t                    w_new;

    assign w_pix_last = (r_pi == OW'(OUT_SIZE - 1)) && (r_pj == OW'(OUT_SIZE - 1));
    assign w_k_last   = (r_m == KW'(KERNEL_SIZE - 1)) && (r_n == KW'(KERNEL_SIZE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_MASK;
            S_MASK:  w_next = S_ACCUM;
            S_ACCUM: if (w_pix_last) w_next = S_WRITE;
            S_WRITE: w_next = w_k_last ? S_IDLE : S_ACCUM;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch  = (r_state == S_IDLE) && bus.start;
        w_mask   = (r_state == S_MASK);
        w_mac_en = (r_state == S_ACCUM);
        w_write  = (r_state == S_WRITE);
        w_busy   = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m    <= '0;
            r_n    <= '0;
            r_pi   <= '0;
            r_pj   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_write && w_k_last;
            if (w_mac_en) begin
                if (r_pj == OW'(OUT_SIZE - 1)) begin
                    r_pj <= '0;
                    r_pi <= (r_pi == OW'(OUT_SIZE - 1)) ? '0 : r_pi + 1'b1;
                end else begin
                    r_pj <= r_pj + 1'b1;
                end
            end
            if (w_write) begin
                if (r_n == KW'(KERNEL_SIZE - 1)) begin
                    r_n <= '0;
                    r_m <= (r_m == KW'(KERNEL_SIZE - 1)) ? '0 : r_m + 1'b1;
                end else begin
                    r_n <= r_n + 1'b1;
                end
            end
        end
    end

    // Operand selection: kernel offset (m,n) slides over output pixel (i,j).
    assign w_a = r_in[IW'(r_pi) + IW'(r_m)][IW'(r_pj) + IW'(r_n)];
    assign w_b = r_delta[r_pi][r_pj];

    seq_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_write),
        .i_en  (w_mac_en),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_acc (w_acc)
    );

    always_comb begin
        w_grad = sat16(48'(w_acc >>> FRAC_BITS));
        w_upd  = r_lr * w_grad;
        w_diff = 48'(r_kin[r_m][r_n]) - 48'(w_upd >>> FRAC_BITS);
        w_new  = sat16(w_diff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in    <= '{default: '0};
            r_cout  <= '{default: '0};
            r_dl    <= '{default: '0};
            r_delta <= '{default: '0};
            r_kin   <= '{default: '0};
            r_stage <= '{default: '0};
            r_kout  <= '{default: '0};
            r_lr    <= '0;
        end else begin
            if (w_latch) begin
                r_in   <= bus.input_feature;
                r_cout <= bus.conv_out;
                r_dl   <= bus.dL_dact;
                r_kin  <= bus.kernel_in;
                r_lr   <= bus.learning_rate;
            end
            if (w_mask) begin
                for (int unsigned i = 0; i < OUT_SIZE; i++)
                    for (int unsigned j = 0; j < OUT_SIZE; j++)
                        r_delta[i][j] <= (r_cout[i][j] > 16'sd0) ? r_dl[i][j] : '0;
            end
            if (w_write) begin
                r_stage[r_m][r_n] <= w_new;
                // The last weight is still being written to stage, so commit it directly.
                if (w_k_last) begin
                    for (int unsigned a = 0; a < KERNEL_SIZE; a++)
                        for (int unsigned b = 0; b < KERNEL_SIZE; b++)
                            r_kout[a][b] <= (KW'(a) == r_m && KW'(b) == r_n) ? w_new : r_stage[a][b];
                end
            end
        end
    end

    assign bus.kernel_out = r_kout;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_conv_kernel_update.sv
// Directed self-checking bench for conv_kernel_update with hand-computed results.
module tb_conv_kernel_update;
    import cnn_pkg::*;

    localparam int IN_SIZE     = 4;
    localparam int KERNEL_SIZE = 3;
    localparam int OUT_SIZE    = IN_SIZE - KERNEL_SIZE + 1;
    localparam int RUN_EDGES   = 46;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] exp_k [KERNEL_SIZE][KERNEL_SIZE];

    conv_kernel_update_if #(.IN_SIZE(IN_SIZE), .KERNEL_SIZE(KERNEL_SIZE)) bus ();

    conv_kernel_update #(
        .IN_SIZE     (IN_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic fill(input logic [15:0] vin, input logic [15:0] vco, input logic [15:0] vdl,
                        input logic [15:0] vlr, input logic [15:0] vk);
        for (int r = 0; r < IN_SIZE; r++)
            for (int c = 0; c < IN_SIZE; c++)
                bus.input_feature[r][c] = vin;
        for (int r = 0; r < OUT_SIZE; r++)
            for (int c = 0; c < OUT_SIZE; c++) begin
                bus.conv_out[r][c] = vco;
                bus.dL_dact[r][c]  = vdl;
            end
        bus.learning_rate = vlr;
        for (int m = 0; m < KERNEL_SIZE; m++)
            for (int n = 0; n < KERNEL_SIZE; n++)
                bus.kernel_in[m][n] = vk;
    endtask

    task automatic set_exp(input logic [15:0] v);
        for (int m = 0; m < KERNEL_SIZE; m++)
            for (int n = 0; n < KERNEL_SIZE; n++)
                exp_k[m][n] = v;
    endtask

    task automatic check_kout(input string tag);
        for (int m = 0; m < KERNEL_SIZE; m++)
            for (int n = 0; n < KERNEL_SIZE; n++)
                check($sformatf("%s_k%0d%0d", tag, m, n), 32'($unsigned(bus.kernel_out[m][n])),
                      32'(exp_k[m][n]));
    endtask

    // Accept one request, then return the number of edges until done is seen (-1 on timeout).
    task automatic run(output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int ndone;

        rst       = 1'b0;
        bus.start = 1'b0;
        fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        set_exp(16'h0000);
        check_kout("rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Uniform: each product 1.0, four pixels -> grad 4.0, step -4.0.
        fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
        run(lat);
        check("uni_latency", 32'(lat), 32'(RUN_EDGES));
        check("uni_busy_at_done", 32'(bus.busy), 32'd0);
        set_exp(16'hFC00);
        check_kout("uni");
        @(posedge clk);
        #1 check("uni_done_width", 32'(bus.done), 32'd0);

        // Reset in the middle of a run clears outputs without a clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_done", 32'(bus.done), 32'd0);
        check("mid_k00", 32'($unsigned(bus.kernel_out[0][0])), 32'd0);
        check("mid_k22", 32'($unsigned(bus.kernel_out[2][2])), 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (80) begin
            @(posedge clk);
            #1 if (bus.done) ndone++;
        end
        check("mid_no_done", 32'(ndone), 32'd0);

        // ReLU mask: negative then zero pre-activation leaves weights untouched.
        fill(16'h0100, 16'hFF00, 16'h0300, 16'h0100, 16'h0000);
        for (int m = 0; m < KERNEL_SIZE; m++)
            for (int n = 0; n < KERNEL_SIZE; n++) begin
                exp_k[m][n]         = 16'($urandom);
                bus.kernel_in[m][n] = exp_k[m][n];
            end
        run(lat);
        check("neg_latency", 32'(lat), 32'(RUN_EDGES));
        check_kout("neg");
        fill(16'h0100, 16'h0000, 16'h0300, 16'h0100, 16'h0000);
        for (int m = 0; m < KERNEL_SIZE; m++)
            for (int n = 0; n < KERNEL_SIZE; n++) begin
                exp_k[m][n]         = 16'($urandom);
                bus.kernel_in[m][n] = exp_k[m][n];
            end
        run(lat);
        check_kout("zero");

        // Single pixel: only delta[0][0]=2.0, lr 0.5 -> weight = -(4m+n).
        fill(16'h0000, 16'h0100, 16'h0000, 16'h0080, 16'h0000);
        for (int r = 0; r < IN_SIZE; r++)
            for (int c = 0; c < IN_SIZE; c++)
                bus.input_feature[r][c] = 16'((4 * r + c) * 256);
        bus.dL_dact[0][0] = 16'h0200;
        for (int m = 0; m < KERNEL_SIZE; m++)
            for (int n = 0; n < KERNEL_SIZE; n++)
                exp_k[m][n] = 16'(0 - (4 * m + n) * 256);
        run(lat);
        check_kout("pix");

        // Saturation: the update overshoots below -128.0 and must clamp.
        fill(16'h7F00, 16'h7F00, 16'h7F00, 16'h0100, 16'h8000);
        set_exp(16'h8000);
        run(lat);
        check_kout("sat");
        // Tiny lr exposes the clamped gradient: 0x7000 - (0x7FFF >>> 8) = 0x6F81.
        fill(16'h7F00, 16'h7F00, 16'h7F00, 16'h0001, 16'h7000);
        run(lat);
        check("satg_k00", 32'($unsigned(bus.kernel_out[0][0])), 32'h6F81);
        check("satg_k22", 32'($unsigned(bus.kernel_out[2][2])), 32'h6F81);

        // start pulsed while busy is ignored.
        fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (n == 9)  bus.start = 1'b1;
            if (n == 10) bus.start = 1'b0;
        end
        check("hs_ignore_count", 32'(ndone), 32'd1);
        check("hs_ignore_latency", 32'(lat), 32'(RUN_EDGES));

        // start held through the done cycle is taken at the next edge.
        fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check("b2b_first", 32'(lat), 32'(RUN_EDGES));
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check("b2b_second", 32'(lat), 32'(RUN_EDGES));
        set_exp(16'hFC00);
        check_kout("b2b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
